// File: rtl/icache_if.sv
//==============================================================================
// Module : icache_if
// Desc   : Fetch-side request/response and memory-controller fill signals
//          shared by the instruction cache and its neighbours.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface icache_if #(
   parameter int ADDR_W = 32
);
   // fetch stage <-> cache
   logic              imemREN;
   logic [ADDR_W-1:0] imemaddr;
   logic              ihit;
   logic [31:0]       imemload;
   // cache <-> memory controller
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              iwait;
   logic [31:0]       iload;

   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

`default_nettype wire

// File: rtl/icache.sv
//==============================================================================
// Module : icache
// Desc   : Direct-mapped, one-word-per-block read-only instruction cache with
//          zero-cycle hits and single-read miss fills from the memory controller.
//          Optional macro ICACHE_STATS_EN adds saturating hit/miss counters.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module icache #(
   parameter int SETS   = 16,
   parameter int ADDR_W = 32
) (
   input  wire logic   CLK,
   input  wire logic   nRST,
   icache_if.slave     bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [SETS-1:0]   r_valid;
   logic [TAG_W-1:0]  r_tag  [SETS];
   logic [31:0]       r_data [SETS];
   logic [ADDR_W-1:0] r_miss_addr;

   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_fill_idx;
   logic [TAG_W-1:0]  w_fill_tag;
   logic              w_lookup_hit;
   logic              w_miss;
   logic              w_fill_done;
   logic [1:0]        w_unused_lsb;

   assign w_idx        = bus.imemaddr[IDX_W+1:2];
   assign w_tag        = bus.imemaddr[ADDR_W-1:IDX_W+2];
   assign w_fill_idx   = r_miss_addr[IDX_W+1:2];
   assign w_fill_tag   = r_miss_addr[ADDR_W-1:IDX_W+2];
   assign w_unused_lsb = bus.imemaddr[1:0];
   assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   always_comb begin
      w_state_nxt  = r_state;
      w_miss       = 1'b0;
      w_fill_done  = 1'b0;
      bus.ihit     = 1'b0;
      bus.imemload = 32'h0;
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      case (r_state)
         ST_IDLE: begin
            if (bus.imemREN) begin
               if (w_lookup_hit) begin
                  bus.ihit     = 1'b1;
                  bus.imemload = r_data[w_idx];
               end else begin
                  w_miss      = 1'b1;
                  w_state_nxt = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            // Fill is bound to the latched miss address; fetch-side changes are ignored.
            bus.iREN  = 1'b1;
            bus.iaddr = r_miss_addr;
            if (!bus.iwait) begin
               w_fill_done = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= ST_IDLE;
         r_miss_addr <= '0;
         r_valid     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_miss) begin
            r_miss_addr <= {bus.imemaddr[ADDR_W-1:2], 2'b00};
         end
         if (w_fill_done) begin
            r_valid[w_fill_idx] <= 1'b1;
         end
      end
   end

   // Tag/data need no reset: a frame is only read once its valid bit is set.
   always_ff @(posedge CLK) begin
      if (w_fill_done) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= bus.iload;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else begin
         if (bus.ihit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (w_miss && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
//==============================================================================
// Module : tb_icache
// Desc   : Scoreboard bench for icache: directed scenarios then random fetches
//          against a tag-array reference model and a behavioural memory.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_icache;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   icache_if bus ();

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .bus        (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   typedef struct {
      logic [31:0] data;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          wait_n;
   } fill_t;

   exp_t        exp_q[$];
   fill_t       fill_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          req_cyc = 0;
   int          reads = 0;
   int          misses = 0;
   int          hits_since = 0;
   int          misses_since = 0;
   bit          m_valid [16];
   logic [25:0] m_tag   [16];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Memory image: two fixed words from the directed scenarios, hash elsewhere.
   function automatic logic [31:0] memword(logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h0000_0000) return 32'h2001_0005;
      if (w == 32'h0000_0040) return 32'hDEAD_BEEF;
      return w * 32'h9E37_79B1 + 32'h1234_5677;
   endfunction

   function automatic bit model_peek(logic [31:0] a);
      return m_valid[int'(a[5:2])] && (m_tag[int'(a[5:2])] == a[31:6]);
   endfunction

   // Returns 1 on hit; on a miss records the expected fill and installs the frame.
   function automatic bit model_access(logic [31:0] a, int w);
      if (model_peek(a)) return 1'b1;
      m_valid[int'(a[5:2])] = 1'b1;
      m_tag[int'(a[5:2])]   = a[31:6];
      fill_q.push_back('{addr: {a[31:2], 2'b00}, wait_n: w});
      misses++;
      misses_since++;
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
      end
   end

   task automatic wait_hit();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge CLK);
         if (bus.ihit) got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL hit_timeout: got no ihit want ihit within 80 cycles");
         exp_q.delete();
         fill_q.delete();
      end
   endtask

   task automatic req(logic [31:0] a, int w);
      bit h;
      h = model_access(a, w);
      @(posedge CLK);
      #1;
      bus.imemREN  = 1'b1;
      bus.imemaddr = a | 32'($urandom_range(0, 3));
      req_cyc      = cyc;
      exp_q.push_back('{data: memword(a), lat: h ? 0 : w + 2});
      wait_hit();
   endtask

   // a1 must miss; the fetch address is redirected to a2 during a1's fill.
   task automatic req_redirect(logic [31:0] a1, int w1, logic [31:0] a2, int w2);
      bit h1;
      bit h2;
      h1 = model_access(a1, w1);
      @(posedge CLK);
      #1;
      bus.imemREN  = 1'b1;
      bus.imemaddr = a1;
      req_cyc      = cyc;
      h2 = model_access(a2, w2);
      exp_q.push_back('{data: memword(a2), lat: (h1 ? 0 : w1 + 2) + (h2 ? 0 : w2 + 2)});
      @(posedge CLK);
      #1;
      bus.imemaddr = a2 | 32'($urandom_range(0, 3));
      wait_hit();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         bus.imemREN  = 1'b0;
         bus.imemaddr = $urandom;
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_ihit"},     32'(bus.ihit), 32'h0);
      check({tag, "_iREN"},     32'(bus.iREN), 32'h0);
      check({tag, "_iaddr"},    bus.iaddr,     32'h0);
      check({tag, "_imemload"}, bus.imemload,  32'h0);
   endtask

   // Monitor: every ihit consumes one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (nRST) begin
            if (bus.ihit) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_hit: got ihit=1 addr %h want ihit=0", bus.imemaddr);
               end else begin
                  e = exp_q.pop_front();
                  check("imemload", bus.imemload, e.data);
                  check("hit_latency", 32'(cyc - req_cyc), 32'(e.lat));
                  hits_since++;
               end
               check("iREN_during_hit", 32'(bus.iREN), 32'h0);
            end else begin
               check("imemload_no_hit", bus.imemload, 32'h0);
            end
         end
      end
   end

   // Memory controller: one read per expected fill, random wait, noise while idle.
   initial begin
      bit          busy;
      int          cnt;
      int          cur_w;
      logic [31:0] cur_a;
      fill_t       f;
      busy      = 1'b0;
      cnt       = 0;
      cur_w     = 0;
      cur_a     = 32'h0;
      bus.iwait = 1'b1;
      bus.iload = 32'h0;
      forever begin
         @(negedge CLK);
         if (nRST && bus.iREN) begin
            if (!busy) begin
               if (fill_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_iREN: got iREN=1 iaddr %h want iREN=0", bus.iaddr);
                  cur_w = 0;
                  cur_a = bus.iaddr;
               end else begin
                  f = fill_q.pop_front();
                  cur_w = f.wait_n;
                  cur_a = f.addr;
               end
               busy = 1'b1;
               cnt  = 0;
            end
            check("iaddr", bus.iaddr, cur_a);
            if (cnt < cur_w) begin
               bus.iwait = 1'b1;
               cnt++;
            end else begin
               bus.iwait = 1'b0;
               bus.iload = memword(bus.iaddr);
               busy      = 1'b0;
               reads++;
            end
         end else begin
            busy      = 1'b0;
            bus.iwait = 1'($urandom);
            bus.iload = $urandom;
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] a2;
      int          w;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0;
      model_clear();

      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      bus.imemREN = 1'b0;
      @(posedge CLK);
      #2;
      nRST = 1'b1;

      req(32'h0000_0000, 3);
      req(32'h0000_0000, 0);
      req(32'h0000_0040, 2);
      req(32'h0000_0000, 1);
`ifdef ICACHE_STATS_EN
      @(negedge CLK);
      check("miss_count_dir", miss_count, 32'(misses_since));
      check("hit_count_dir",  hit_count,  32'(hits_since));
`endif

      req_redirect(32'h0000_0104, 3, 32'h0000_0200, 2);
      req(32'h0000_0104, 0);
      req(32'h0000_0200, 0);

      // Reset during a long fill: abandoned fill leaves no frame behind.
      a = 32'h0000_0300;
      void'(model_access(a, 20));
      @(posedge CLK);
      #1;
      bus.imemREN  = 1'b1;
      bus.imemaddr = a;
      repeat (3) @(posedge CLK);
      #3;
      check("fill_in_progress", 32'(bus.iREN), 32'h1);
      nRST = 1'b0;
      #1;
      check_reset_outputs("midfill_reset");
      bus.imemREN = 1'b0;
      exp_q.delete();
      fill_q.delete();
      model_clear();
      misses--;
      hits_since   = 0;
      misses_since = 0;
`ifdef ICACHE_STATS_EN
      check("hit_count_reset",  hit_count,  32'h0);
      check("miss_count_reset", miss_count, 32'h0);
`endif
      @(posedge CLK);
      #2;
      nRST = 1'b1;
      req(32'h0000_0000, 2);
      req(32'h0000_0300, 1);

      for (int n = 0; n < 300; n++) begin
         a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 9) == 0) a[31:28] = 4'($urandom);
         w = $urandom_range(0, 4);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if (($urandom_range(0, 7) == 0) && !model_peek(a)) begin
            a2 = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            req_redirect(a, w, a2, $urandom_range(0, 4));
         end else begin
            req(a, w);
         end
      end
      idle(3);

      check("reads_per_miss", 32'(reads),          32'(misses));
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      check("fills_empty",      32'(fill_q.size()), 32'h0);
`ifdef ICACHE_STATS_EN
      check("hit_count",  hit_count,  32'(hits_since));
      check("miss_count", miss_count, 32'(misses_since));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish want finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
